// File: rtl/board_evaluator.sv
// Material-score accelerator: reads candidate boards from SDRAM, writes one signed score per board, tracks the best.
// Optional macro CENTRE_BONUS_EN adds +/-10 for occupied centre squares (27, 28, 35, 36).
module board_evaluator #(
    parameter int MAX_BOARDS = 64,
    parameter int PAWN_VAL   = 100,
    parameter int ROOK_VAL   = 500,
    parameter int KNIGHT_VAL = 320,
    parameter int BISHOP_VAL = 330,
    parameter int QUEEN_VAL  = 900,
    parameter int KING_VAL   = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    localparam int CW = $clog2(MAX_BOARDS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RD_REQ, RD_WAIT, WR, UPD, DONE} state_t;

    state_t             state;
    logic [31:0]        src_base;
    logic [31:0]        res_base;
    logic [CW-1:0]      count;
    logic [CW-1:0]      board_idx;
    logic [5:0]         sq;
    logic signed [31:0] acc;
    logic signed [31:0] best_score;
    logic [CW-1:0]      best_index;
    logic signed [31:0] contrib;
    logic signed [31:0] acc_next;
    logic               idle_or_done;
    logic               unused_upper;

    assign unused_upper = &{1'b0, master_readdata[31:8]};
    assign idle_or_done = (state == IDLE) || (state == DONE);
    assign acc_next     = acc + contrib;

    function automatic logic signed [31:0] piece_value(input logic [7:0] code);
        logic [7:0]         mag;
        logic signed [31:0] v;
        // 0x80 negates to itself (128), which falls outside every range below.
        mag = code[7] ? (~code + 8'd1) : code;
        if      (mag >= 8'd1  && mag <= 8'd8)  v = PAWN_VAL;
        else if (mag >= 8'd9  && mag <= 8'd18) v = ROOK_VAL;
        else if (mag >= 8'd19 && mag <= 8'd28) v = KNIGHT_VAL;
        else if (mag >= 8'd29 && mag <= 8'd38) v = BISHOP_VAL;
        else if (mag >= 8'd39 && mag <= 8'd47) v = QUEEN_VAL;
        else if (mag == 8'd48)                 v = KING_VAL;
        else                                   v = 0;
        return code[7] ? -v : v;
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        contrib = piece_value(master_readdata[7:0]);
`ifdef CENTRE_BONUS_EN
        if ((sq == 6'd27 || sq == 6'd28 || sq == 6'd35 || sq == 6'd36) &&
            master_readdata[7:0] != 8'd0)
            contrib = master_readdata[7] ? contrib - 32'sd10 : contrib + 32'sd10;
`endif
    end

    // NOTE: all state lives in one clocked block with non-blocking assignments, so every read sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            src_base          <= '0;
            res_base          <= '0;
            count             <= '0;
            board_idx         <= '0;
            sq                <= '0;
            acc               <= '0;
            best_score        <= '0;
            best_index        <= '0;
            slave_waitrequest <= 1'b1;
            slave_readdata    <= '0;
            master_address    <= '0;
            master_read       <= 1'b0;
            master_write      <= 1'b0;
            master_writedata  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    acc            <= '0;
                    sq             <= '0;
                    master_read    <= 1'b1;
                    master_address <= src_base + (32'(board_idx) << 8);
                    state          <= RD_REQ;
                end
                RD_REQ: begin
                    if (!master_waitrequest) begin
                        master_read <= 1'b0;
                        state       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (master_readdatavalid) begin
                        acc <= acc_next;
                        if (sq != 6'd63) begin
                            sq             <= sq + 6'd1;
                            master_read    <= 1'b1;
                            master_address <= src_base + (32'(board_idx) << 8)
                                            + (32'(sq + 6'd1) << 2);
                            state          <= RD_REQ;
                        end else begin
                            master_write     <= 1'b1;
                            master_address   <= res_base + (32'(board_idx) << 2);
                            master_writedata <= acc_next;
                            state            <= WR;
                        end
                    end
                end
                WR: begin
                    if (!master_waitrequest) begin
                        master_write <= 1'b0;
                        state        <= UPD;
                    end
                end
                UPD: begin
                    // Strict compare keeps the earliest board on ties; board 0 always seeds the best.
                    if (board_idx == '0 || acc > best_score) begin
                        best_score <= acc;
                        best_index <= board_idx;
                    end
                    board_idx <= board_idx + CW'(1);
                    state     <= (board_idx + CW'(1) < count) ? LOAD : DONE;
                end
                DONE:    state <= IDLE;
                default: ;
            endcase

            // Control port: accesses are only accepted when no run is in flight.
            if (!slave_waitrequest) begin
                slave_waitrequest <= 1'b1;
            end else if ((slave_read || slave_write) && idle_or_done) begin
                slave_waitrequest <= 1'b0;
                if (slave_write) begin
                    case (slave_address)
                        4'd0: begin
                            board_idx <= '0;
                            state     <= (count == '0) ? DONE : LOAD;
                        end
                        4'd1: src_base <= slave_writedata;
                        4'd2: res_base <= slave_writedata;
                        4'd3: count    <= (slave_writedata > 32'(MAX_BOARDS)) ? CW'(MAX_BOARDS)
                                                                             : slave_writedata[CW-1:0];
                        default: ;
                    endcase
                end else begin
                    case (slave_address)
                        4'd0:    slave_readdata <= 32'(board_idx);
                        4'd5:    slave_readdata <= best_score;
                        4'd6:    slave_readdata <= 32'(best_index);
                        default: slave_readdata <= '0;
                    endcase
                end
            end
        end
    end

endmodule
